// File: rtl/btn_press_classifier.sv
// Classifies a debounced button level into single-cycle press, release,
// short, long, auto-repeat and double-click pulses plus a held level.
module btn_press_classifier #(
    parameter int LONG_CYCLES   = 100_000_000,
    parameter int REPEAT_CYCLES = 20_000_000,
    parameter int DBL_CYCLES    = 30_000_000,
    parameter int CNT_W         = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic double_click,
    output logic held
);

    typedef enum logic [2:0] {
        IDLE,
        HELD,
        LONG_HELD,
        WAIT_DBL,
        DBL_HELD
    } state_t;

    localparam logic [CNT_W-1:0] longLast   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] repeatLast = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] dblLast    = CNT_W'(DBL_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             btnQ;
    logic             rise;

    // btnQ resets high so a button held through reset must be released first
    assign rise = btn_in & ~btnQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            btnQ          <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            double_click  <= 1'b0;
            held          <= 1'b0;
        end else begin
            btnQ          <= btn_in;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            double_click  <= 1'b0;

            case (state)
                IDLE: begin
                    if (rise) begin
                        press_pulse <= 1'b1;
                        held        <= 1'b1;
                        cnt         <= '0;
                        state       <= HELD;
                    end
                end

                // A release on the terminal-count edge still counts as short
                HELD: begin
                    if (!btn_in) begin
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                        cnt           <= '0;
                        state         <= WAIT_DBL;
                    end else if (cnt == longLast) begin
                        long_press <= 1'b1;
                        cnt        <= '0;
                        state      <= LONG_HELD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                LONG_HELD: begin
                    if (!btn_in) begin
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                        cnt           <= '0;
                        state         <= IDLE;
                    end else if (cnt == repeatLast) begin
                        repeat_pulse <= 1'b1;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // A press on the timeout edge wins over the short classification
                WAIT_DBL: begin
                    if (btn_in) begin
                        double_click <= 1'b1;
                        press_pulse  <= 1'b1;
                        held         <= 1'b1;
                        cnt          <= '0;
                        state        <= DBL_HELD;
                    end else if (cnt == dblLast) begin
                        short_press <= 1'b1;
                        cnt         <= '0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DBL_HELD: begin
                    if (!btn_in) begin
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                        cnt           <= '0;
                        state         <= IDLE;
                    end
                end

                default: begin
                    held  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_press_classifier.sv
// Bench for btn_press_classifier: vector table with a one-cycle scoreboard
// queue, plus hand-written reset-through-hold and mid-cycle reset sequences.
module tb_btn_press_classifier;

    localparam int LONG_CYCLES   = 10;
    localparam int REPEAT_CYCLES = 4;
    localparam int DBL_CYCLES    = 6;
    localparam int CNT_W         = 5;

    // Output vector bit positions
    localparam logic [6:0] P  = 7'b0000001;
    localparam logic [6:0] R  = 7'b0000010;
    localparam logic [6:0] S  = 7'b0000100;
    localparam logic [6:0] L  = 7'b0001000;
    localparam logic [6:0] RP = 7'b0010000;
    localparam logic [6:0] D  = 7'b0100000;
    localparam logic [6:0] H  = 7'b1000000;

    typedef struct packed {
        logic       btn;
        logic [6:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btnIn = 1'b1;
    logic pressPulse, releasePulse, shortPress, longPress, repeatPulse, doubleClick, held;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];
    logic [6:0] expQ[$];

    btn_press_classifier #(
        .LONG_CYCLES  (LONG_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES),
        .DBL_CYCLES   (DBL_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (btnIn),
        .press_pulse  (pressPulse),
        .release_pulse(releasePulse),
        .short_press  (shortPress),
        .long_press   (longPress),
        .repeat_pulse (repeatPulse),
        .double_click (doubleClick),
        .held         (held)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {held, doubleClick, repeatPulse, longPress, shortPress, releasePulse, pressPulse};
    endfunction

    task automatic check(input string name, input int idx, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s idx=%0d got=%b exp=%b (H D RP L S R P)", name, idx, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge
    task automatic step(input string name, input int idx, input logic b, input logic [6:0] e);
        logic [6:0] want;
        btnIn = b;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        want = expQ.pop_front();
        check(name, idx, outs(), want);
    endtask

    task automatic addSeg(input logic b, input int n);
        for (int i = 0; i < n; i++) vecs.push_back('{btn: b, exp: 7'b0});
    endtask

    task automatic mark(input int idx, input logic [6:0] m);
        vec_t tmp;
        tmp = vecs[idx];
        tmp.exp = tmp.exp | m;
        vecs[idx] = tmp;
    endtask

    task automatic markHeld(input int from, input int to);
        for (int i = from; i <= to; i++) mark(i, H);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog idx=0 got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;

        // Held through reset: ignored until released and pressed again
        t = vecs.size();
        addSeg(1'b1, 30); addSeg(1'b0, 1); addSeg(1'b1, 1); addSeg(1'b0, 9);
        mark(t + 31, P | H);
        mark(t + 32, R);
        mark(t + 38, S);

        // Short press: high 3
        t = vecs.size() + 2;
        addSeg(1'b0, 2); addSeg(1'b1, 3); addSeg(1'b0, 12);
        mark(t, P); markHeld(t, t + 2);
        mark(t + 3, R);
        mark(t + 9, S);

        // Long press with repeats: high 20
        t = vecs.size() + 2;
        addSeg(1'b0, 2); addSeg(1'b1, 20); addSeg(1'b0, 4);
        mark(t, P); markHeld(t, t + 19);
        mark(t + 10, L);
        mark(t + 14, RP);
        mark(t + 18, RP);
        mark(t + 20, R);

        // Double click: high 3, low 2, high 20
        t = vecs.size() + 2;
        addSeg(1'b0, 2); addSeg(1'b1, 3); addSeg(1'b0, 2); addSeg(1'b1, 20); addSeg(1'b0, 4);
        mark(t, P); markHeld(t, t + 2);
        mark(t + 3, R);
        mark(t + 5, P | D); markHeld(t + 5, t + 24);
        mark(t + 25, R);

        // Release on the long terminal-count edge: short, never long
        t = vecs.size() + 2;
        addSeg(1'b0, 2); addSeg(1'b1, 10); addSeg(1'b0, 10);
        mark(t, P); markHeld(t, t + 9);
        mark(t + 10, R);
        mark(t + 16, S);

        // Second press on the double-click timeout edge: double click wins
        t = vecs.size() + 2;
        addSeg(1'b0, 2); addSeg(1'b1, 3); addSeg(1'b0, 6); addSeg(1'b1, 2); addSeg(1'b0, 8);
        mark(t, P); markHeld(t, t + 2);
        mark(t + 3, R);
        mark(t + 9, P | D); markHeld(t + 9, t + 10);
        mark(t + 11, R);

        // Reset state with the button held
        rst = 1'b1;
        btnIn = 1'b1;
        #2;
        check("reset_async", 0, outs(), 7'b0);
        @(posedge clk); #1;
        check("reset_clk", 1, outs(), 7'b0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step("table", i, vecs[i].btn, vecs[i].exp);
        end

        // Reach LONG_HELD, then reset mid-cycle while long_press is high
        step("lh_idle", 0, 1'b0, 7'b0);
        for (int k = 0; k <= 10; k++) begin
            step("lh_hold", k, 1'b1, H | ((k == 0) ? P : 7'b0) | ((k == 10) ? L : 7'b0));
        end
        #3;
        rst = 1'b1;
        #1;
        check("midreset_drop", 0, outs(), 7'b0);
        step("midreset_hold", 1, 1'b1, 7'b0);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) step("post_reset_held", k, 1'b1, 7'b0);
        step("post_reset_low", 0, 1'b0, 7'b0);
        step("post_reset_low", 1, 1'b0, 7'b0);
        step("post_reset_press", 0, 1'b1, P | H);
        step("post_reset_release", 0, 1'b0, R);

        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain idx=0 got=%0d exp=0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btn_press_classifier.md
Name: btn_press_classifier

Overview:
- Consumes the clean, synchronous level from debouncer_long and classifies each press into single-cycle event pulses: press, release, short press, long press, auto-repeat and double click.
- Game/UI control logic downstream uses these pulses instead of raw button levels.
- Sits directly after the debouncer in the clk domain (100 MHz).

Parameters:
- LONG_CYCLES, 100_000_000, hold time in clk cycles before long_press fires (1 s).
- REPEAT_CYCLES, 20_000_000, period of repeat_pulse while the button is held after long_press (200 ms).
- DBL_CYCLES, 30_000_000, window after a short release in which a new press counts as a double click (300 ms).
- CNT_W, 27, counter width. Must hold max(LONG_CYCLES, REPEAT_CYCLES, DBL_CYCLES) - 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn_in  input  1  debounced button level from debouncer_long, synchronous to clk.
- press_pulse  output  1  one-cycle pulse on each accepted rising edge.
- release_pulse  output  1  one-cycle pulse on each falling edge while held.
- short_press  output  1  one-cycle pulse: press released before LONG_CYCLES, with no second press inside the window.
- long_press  output  1  one-cycle pulse when a hold reaches LONG_CYCLES.
- repeat_pulse  output  1  one-cycle pulse every REPEAT_CYCLES after long_press while still held.
- double_click  output  1  one-cycle pulse on a second press inside the DBL window.
- held  output  1  level; high while in HELD, LONG_HELD or DBL_HELD.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values:
  - All outputs are 0.
  - State is IDLE and cnt is 0.
  - btn_q (registered copy of btn_in) resets to 1, so a button held through reset never produces a press; it must be released first.
- Edge signals: rise = btn_in & ~btn_q; fall = ~btn_in & btn_q.
- Outputs are registered. Every pulse is high for exactly the one cycle after the clk edge that decides it. Pulses default to 0 each cycle.
- IDLE:
  - On rise: press_pulse<=1, cnt<=0, go to HELD.
- HELD:
  - If btn_in=0: release_pulse<=1, cnt<=0, go to WAIT_DBL.
  - Else if cnt==LONG_CYCLES-1: long_press<=1, cnt<=0, go to LONG_HELD.
  - Else: cnt<=cnt+1.
  - Result: long_press goes high exactly LONG_CYCLES cycles after press_pulse.
  - If release and terminal count occur on the same edge, release wins and the press is classified as short.
- LONG_HELD:
  - If btn_in=0: release_pulse<=1, go to IDLE. No short_press is generated.
  - Else if cnt==REPEAT_CYCLES-1: repeat_pulse<=1, cnt<=0.
  - Else: cnt<=cnt+1.
- WAIT_DBL:
  - If btn_in=1: double_click<=1 and press_pulse<=1 in the same cycle, go to DBL_HELD. No short_press is generated.
  - Else if cnt==DBL_CYCLES-1: short_press<=1, go to IDLE. Result: short_press goes high DBL_CYCLES cycles after release_pulse.
  - Else: cnt<=cnt+1.
  - A press and the timeout on the same edge is treated as a double click.
- DBL_HELD:
  - No counting. No long_press or repeat_pulse is generated.
  - On btn_in=0: release_pulse<=1, go to IDLE.
- Mutual exclusion: at most one of short_press, long_press, repeat_pulse and release_pulse is high in any cycle. press_pulse and double_click coincide only as stated in WAIT_DBL.
- Counter: cnt never wraps; it is cleared on every state change. Parameter values of 1 are legal and mean the event fires on the first eligible edge.
- Reset mid-operation: all outputs go to 0 and state goes to IDLE immediately, without waiting for clk. A button still high afterwards is ignored until it drops and rises again.

Test Plan (parameters LONG_CYCLES=10, REPEAT_CYCLES=4, DBL_CYCLES=6):
1. Reset while btn_in=1, release rst, hold btn_in=1 for 30 cycles -> all outputs stay 0 and held=0. Then drop btn_in and raise it -> press_pulse fires 1 cycle later.
2. Short press: btn_in high 3 cycles, then low -> press_pulse at t, release_pulse at t+3, short_press at t+9, held high during t..t+2. No long_press.
3. Long press with repeat: btn_in high 20 cycles -> press_pulse at t, long_press at t+10, repeat_pulse at t+14 and t+18, release_pulse on release. No short_press afterwards.
4. Double click: high 3, low 2, high 20 -> double_click and press_pulse together on the second press. No short_press, long_press or repeat_pulse. One release_pulse at the end, then IDLE.
5. Boundary: btn_in high exactly 10 cycles -> release on the terminal-count edge wins: release_pulse fires, long_press never fires, and short_press follows 6 cycles later.
6. Async reset asserted mid-cycle during LONG_HELD -> all outputs drop to 0 before the next clk edge. No repeat_pulse appears after rst deasserts while btn_in is still high.
